loader_controller: RTL and testbench
====================================

LOADER_CONTROLLER -- requirements
Module: loader_controller

Interface
REQ-001 SHALL have parameter INST_MEM_WIDTH, default 2, instruction-memory address width in bits (depth 2^INST_MEM_WIDTH words).
REQ-002 SHALL have port CLK  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port load_start  input  1  start-load push switch, asynchronous level.
REQ-005 SHALL have port load_end  input  1  end-load push switch, asynchronous level.
REQ-006 SHALL have port rx_data  input  8  received UART byte.
REQ-007 SHALL have port rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-008 SHALL have port imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 SHALL have port imem_addr  output  INST_MEM_WIDTH  instruction-memory write address.
REQ-010 SHALL have port imem_wdata  output  32  instruction word to write.
REQ-011 SHALL have port cpu_run  output  1  high = pipeline may fetch and execute.
REQ-012 SHALL have port cpu_hold  output  1  high = pipeline held in reset/flush; always equal to ~cpu_run.
REQ-013 SHALL have port word_count  output  INST_MEM_WIDTH+1  words written in current load.
REQ-014 SHALL have port overflow  output  1  sticky: a word arrived with memory full.
REQ-015 SHALL have port partial  output  1  sticky: load ended with 1-3 bytes of an incomplete word.

Function
REQ-016 SHALL pass load_start and load_end each through a 2-flop synchronizer plus an edge register; only a rising edge acts. A switch rising before clock edge k produces its internal pulse in the cycle after edge k+2; the resulting state change is visible on outputs after edge k+3.
REQ-017 SHALL implement states IDLE, LOAD, RUN.
REQ-018 IDLE: cpu_run=0; start pulse -> LOAD; end pulse ignored.
REQ-019 Entering LOAD (from IDLE or RUN) SHALL clear byte counter, word_count, overflow, partial, and force cpu_run=0 in the same cycle.
REQ-020 LOAD: each rx_valid SHALL shift rx_data into a 32-bit assembly register, first byte -> bits 31:24 (big-endian); rx_valid outside LOAD SHALL be ignored.
REQ-021 On the 4th byte, the cycle after that rx_valid SHALL assert imem_we for exactly one cycle with imem_addr=word_count[INST_MEM_WIDTH-1:0], imem_wdata=assembled word; word_count SHALL increment on the same edge imem_we deasserts (i.e. visible one cycle after the write).
REQ-022 When word_count = 2^INST_MEM_WIDTH, a completed word SHALL NOT write, word_count SHALL saturate (no wrap), overflow SHALL set.
REQ-023 LOAD: end pulse -> RUN. If byte counter != 0, the bytes SHALL be discarded and partial SHALL set.
REQ-024 End pulse in the same cycle as a 4th-byte rx_valid: the word SHALL be written (imem_we next cycle) and then RUN entered; cpu_run SHALL rise no earlier than the cycle after imem_we.
REQ-025 Start pulse in LOAD SHALL restart the load (REQ-019); start and end pulses in the same cycle: start wins.
REQ-026 RUN: cpu_run=1; end pulse ignored; start pulse -> LOAD (reload). word_count, overflow, partial SHALL hold their values during RUN.
REQ-027 imem_we SHALL never assert outside LOAD except the single deferred write of REQ-024.

Reset
REQ-028 reset SHALL asynchronously force state=IDLE, imem_we=0, imem_addr=0, imem_wdata=0, cpu_run=0, cpu_hold=1, word_count=0, overflow=0, partial=0, byte counter=0, synchronizer/edge flops=0.
REQ-029 reset asserted mid-LOAD SHALL abort without any further imem_we; a switch held high across reset release SHALL NOT generate a pulse.

Verification
REQ-030 Normal load: start, bytes 3C 08 00 01 24 09 00 02, end -> writes 0x3C080001@0, 0x24090002@1, word_count=2, cpu_run=1, overflow=0, partial=0.
REQ-031 Overflow (width 2): 5 full words -> writes at addrs 0-3 only, word_count=4, overflow=1, no 5th imem_we.
REQ-032 Partial: 1 word + bytes AA BB, end -> one write, partial=1, cpu_run=1, word_count=1.
REQ-033 Coincident end with 4th byte -> word written, cpu_run rises the cycle after imem_we.
REQ-034 Reload from RUN: start pulse -> cpu_run=0 after sync latency, word_count=0, new bytes written from addr 0.
REQ-035 Reset after 6 bytes in LOAD -> all outputs at REQ-028 values immediately, no imem_we afterwards, start held high across release gives no LOAD entry.

Source files
------------

// File: rtl/loader_controller.sv
// Loader controller: debounces-free synchronised load switches, big-endian UART
// byte assembly into 32-bit instruction words, and CPU run/hold gating.
module loader_controller #(
  parameter int INST_MEM_WIDTH = 2
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      load_start,
  input  logic                      load_end,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      imem_we,
  output logic [INST_MEM_WIDTH-1:0] imem_addr,
  output logic [31:0]               imem_wdata,
  output logic                      cpu_run,
  output logic                      cpu_hold,
  output logic [INST_MEM_WIDTH:0]   word_count,
  output logic                      overflow,
  output logic                      partial
);

  localparam int CW = INST_MEM_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH  = {1'b1, {INST_MEM_WIDTH{1'b0}}};
  localparam logic [CW-1:0] WC_ONE = {{INST_MEM_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  // Bits [1:0] are the synchroniser, bit [2] holds the previous synchronised level.
  logic [2:0] start_sync_q, end_sync_q;
  logic       start_arm_q, end_arm_q;
  logic       start_pulse_q, end_pulse_q;
  logic [1:0] warm_q;

  // A switch arms only after it has been seen released once reset is over, so
  // a switch held through reset release never produces a press.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      start_sync_q  <= '0;
      end_sync_q    <= '0;
      start_arm_q   <= 1'b0;
      end_arm_q     <= 1'b0;
      start_pulse_q <= 1'b0;
      end_pulse_q   <= 1'b0;
      warm_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
      // which is what makes this shift chain a chain and not a single wire.
      start_sync_q  <= {start_sync_q[1:0], load_start};
      end_sync_q    <= {end_sync_q[1:0], load_end};
      if (!warm_q[1]) warm_q <= warm_q + 2'd1;
      start_arm_q   <= start_arm_q | (warm_q[1] & ~start_sync_q[1]);
      end_arm_q     <= end_arm_q | (warm_q[1] & ~end_sync_q[1]);
      start_pulse_q <= start_arm_q & start_sync_q[1] & ~start_sync_q[2];
      end_pulse_q   <= end_arm_q & end_sync_q[1] & ~end_sync_q[2];
    end
  end

  state_e                    state_q, state_d;
  logic [1:0]                byte_cnt_q, byte_cnt_d;
  logic [23:0]               asm_q, asm_d;
  logic                      we_q, we_d;
  logic [INST_MEM_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [CW-1:0]             wc_q, wc_d;
  logic                      ovf_q, ovf_d;
  logic                      part_q, part_d;
  logic                      end_pend_q, end_pend_d;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wc_q       <= '0;
      ovf_q      <= 1'b0;
      part_q     <= 1'b0;
      end_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wc_q       <= wc_d;
      ovf_q      <= ovf_d;
      part_q     <= part_d;
      end_pend_q <= end_pend_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // one unassigned, which would infer a latch.
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wc_d       = we_q ? wc_q + WC_ONE : wc_q;
    ovf_d      = ovf_q;
    part_d     = part_q;
    end_pend_d = 1'b0;

    if (start_pulse_q) begin
      state_d    = LOAD;
      byte_cnt_d = '0;
      wc_d       = '0;
      ovf_d      = 1'b0;
      part_d     = 1'b0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (end_pend_q) begin
            state_d = RUN;
          end else begin
            if (rx_valid) begin
              asm_d = {asm_q[15:0], rx_data};
              if (byte_cnt_q == 2'd3) begin
                byte_cnt_d = '0;
                if (wc_q == DEPTH) begin
                  ovf_d = 1'b1;
                end else begin
                  we_d    = 1'b1;
                  addr_d  = wc_q[INST_MEM_WIDTH-1:0];
                  wdata_d = {asm_q, rx_data};
                end
              end else begin
                byte_cnt_d = byte_cnt_q + 2'd1;
              end
            end
            // A word completing with the end press is written before RUN starts.
            if (end_pulse_q) begin
              if (rx_valid && byte_cnt_q == 2'd3) begin
                end_pend_d = 1'b1;
              end else begin
                state_d    = RUN;
                byte_cnt_d = '0;
                if (rx_valid || byte_cnt_q != 2'd0) part_d = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_run    = (state_q == RUN);
  assign cpu_hold   = ~cpu_run;
  assign word_count = wc_q;
  assign overflow   = ovf_q;
  assign partial    = part_q;

endmodule

// File: tb/tb_loader_controller.sv
// Self-checking bench for loader_controller: a queue-based loader model checked
// every cycle, plus literal expectations for the headline load scenarios.
module tb_loader_controller;

  localparam int W     = 2;
  localparam int DEPTH = 1 << W;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start, load_end;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          imem_we;
  logic [W-1:0]  imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_run, cpu_hold;
  logic [W:0]    word_count;
  logic          overflow, partial;

  loader_controller #(.INST_MEM_WIDTH(W)) dut (
    .CLK        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_end   (load_end),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .cpu_hold   (cpu_hold),
    .word_count (word_count),
    .overflow   (overflow),
    .partial    (partial)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Loader model: a mode, a queue of pending bytes and the last write issued.
  typedef enum int {M_IDLE, M_LOAD, M_RUN} mode_t;
  mode_t        m_mode;
  logic [7:0]   m_bytes[$];
  int           m_wc;
  bit           m_ovf, m_part, m_we, m_pend;
  int           m_addr;
  logic [31:0]  m_wdata;
  bit [3:0]     st_hist, en_hist;

  task automatic model_reset();
    m_mode = M_IDLE;
    m_bytes.delete();
    m_wc = 0; m_ovf = 0; m_part = 0; m_we = 0; m_pend = 0;
    m_addr = 0; m_wdata = '0;
    st_hist = 4'hF;
    en_hist = 4'hF;
  endtask

  // A switch rise sampled at edge k takes effect at edge k+3.
  task automatic model_step(input bit s, input bit e, input bit v, input logic [7:0] d);
    bit s_act, e_act, word_done, prev_we;
    logic [31:0] word;
    s_act   = st_hist[2] && !st_hist[3];
    e_act   = en_hist[2] && !en_hist[3];
    st_hist = {st_hist[2:0], s};
    en_hist = {en_hist[2:0], e};
    prev_we = m_we;
    m_we    = 0;
    if (prev_we) m_wc++;
    if (s_act) begin
      m_mode = M_LOAD;
      m_bytes.delete();
      m_wc = 0; m_ovf = 0; m_part = 0; m_pend = 0;
    end else if (m_mode == M_LOAD) begin
      if (m_pend) begin
        m_mode = M_RUN;
        m_pend = 0;
      end else begin
        word_done = 0;
        if (v) begin
          m_bytes.push_back(d);
          if (m_bytes.size() == 4) begin
            word = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
            m_bytes.delete();
            word_done = 1;
            if (m_wc == DEPTH) m_ovf = 1;
            else begin
              m_we = 1; m_addr = m_wc; m_wdata = word;
            end
          end
        end
        if (e_act) begin
          if (word_done) m_pend = 1;
          else begin
            m_mode = M_RUN;
            if (m_bytes.size() != 0) m_part = 1;
            m_bytes.delete();
          end
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (!reset) model_step(load_start, load_end, rx_valid, rx_data);
  end

  logic [W-1:0] wlog_addr[$];
  logic [31:0]  wlog_data[$];

  always @(negedge clk) begin
    if (!reset && cmp_en) begin
      check("imem_we",    32'(imem_we),    32'(m_we));
      check("imem_addr",  32'(imem_addr),  32'(m_addr));
      check("imem_wdata", imem_wdata,      m_wdata);
      check("cpu_run",    32'(cpu_run),    32'(m_mode == M_RUN));
      check("cpu_hold",   32'(cpu_hold),   32'(m_mode != M_RUN));
      check("word_count", 32'(word_count), 32'(m_wc));
      check("overflow",   32'(overflow),   32'(m_ovf));
      check("partial",    32'(partial),    32'(m_part));
      if (imem_we) begin
        wlog_addr.push_back(imem_addr);
        wlog_data.push_back(imem_wdata);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input bit s, input bit e);
    if (s) load_start = 1'b1;
    if (e) load_end = 1'b1;
    cyc(4);
    load_start = 1'b0;
    load_end   = 1'b0;
    cyc(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    cyc(1);
    rx_valid = 1'b0;
    cyc(1);
  endtask

  task automatic clear_log();
    wlog_addr.delete();
    wlog_data.delete();
  endtask

  task automatic check_state(input string tag, input bit run, input int wc, input bit ovf, input bit part);
    check({tag, "_run"},  32'(cpu_run),    32'(run));
    check({tag, "_hold"}, 32'(cpu_hold),   32'(!run));
    check({tag, "_wc"},   32'(word_count), 32'(wc));
    check({tag, "_ovf"},  32'(overflow),   32'(ovf));
    check({tag, "_part"}, 32'(partial),    32'(part));
  endtask

  logic [7:0] normal_bytes[8] = '{8'h3C, 8'h08, 8'h00, 8'h01, 8'h24, 8'h09, 8'h00, 8'h02};

  initial begin
    reset = 1'b1; load_start = 1'b0; load_end = 1'b0; rx_data = '0; rx_valid = 1'b0;
    model_reset();
    cyc(3);
    check("rst_we", 32'(imem_we), 32'd0);
    check_state("rst", 0, 0, 0, 0);
    reset  = 1'b0;
    cmp_en = 1'b1;
    cyc(4);

    // End press and bytes while idle do nothing.
    press(0, 1);
    send_byte(8'h55);
    check_state("idle", 0, 0, 0, 0);

    // Normal two-word load.
    clear_log();
    press(1, 0);
    check_state("load1", 0, 0, 0, 0);
    foreach (normal_bytes[i]) send_byte(normal_bytes[i]);
    press(0, 1);
    check("norm_nwr", wlog_addr.size(), 32'd2);
    if (wlog_addr.size() == 2) begin
      check("norm_a0", 32'(wlog_addr[0]), 32'd0);
      check("norm_d0", wlog_data[0], 32'h3C08_0001);
      check("norm_a1", 32'(wlog_addr[1]), 32'd1);
      check("norm_d1", wlog_data[1], 32'h2409_0002);
    end
    check_state("norm", 1, 2, 0, 0);

    // Bytes in RUN are ignored and counters hold.
    repeat (4) send_byte(8'h77);
    check("run_nwr", wlog_addr.size(), 32'd2);
    check_state("runhold", 1, 2, 0, 0);

    // Reload from RUN, then overflow with five words.
    clear_log();
    press(1, 0);
    check_state("reload", 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) send_byte(8'(8'h10 + i));
    check("ovf_nwr", wlog_addr.size(), 32'd4);
    if (wlog_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) check("ovf_addr", 32'(wlog_addr[i]), 32'(i));
      check("ovf_d0", wlog_data[0], 32'h1011_1213);
      check("ovf_d3", wlog_data[3], 32'h1C1D_1E1F);
    end
    check_state("ovf_load", 0, 4, 1, 0);
    press(0, 1);
    check_state("ovf_run", 1, 4, 1, 0);

    // One word plus two stray bytes.
    clear_log();
    press(1, 0);
    check_state("part_clr", 0, 0, 0, 0);
    foreach (normal_bytes[i]) if (i < 4) send_byte(8'h11 * (i + 1));
    send_byte(8'hAA);
    send_byte(8'hBB);
    press(0, 1);
    check("part_nwr", wlog_addr.size(), 32'd1);
    if (wlog_addr.size() == 1) check("part_d0", wlog_data[0], 32'h1122_3344);
    check_state("part", 1, 1, 0, 1);

    // End press coincident with the fourth byte.
    clear_log();
    press(1, 0);
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    load_end = 1'b1;
    cyc(3);
    rx_data  = 8'hEF;
    rx_valid = 1'b1;
    cyc(1);
    rx_valid = 1'b0;
    check("coin_we",    32'(imem_we), 32'd1);
    check("coin_run0",  32'(cpu_run), 32'd0);
    check("coin_wdata", imem_wdata,   32'hDEAD_BEEF);
    check("coin_addr",  32'(imem_addr), 32'd0);
    cyc(1);
    check("coin_we0",   32'(imem_we), 32'd0);
    check("coin_run1",  32'(cpu_run), 32'd1);
    cyc(2);
    load_end = 1'b0;
    cyc(4);
    check_state("coin", 1, 1, 0, 0);

    // Start and end together during LOAD: start wins and restarts.
    clear_log();
    press(1, 0);
    send_byte(8'h01);
    send_byte(8'h02);
    press(1, 1);
    check_state("both", 0, 0, 0, 0);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
    check("both_nwr", wlog_addr.size(), 32'd1);
    if (wlog_addr.size() == 1) check("both_d0", wlog_data[0], 32'hA1A2_A3A4);
    press(0, 1);
    check_state("both_end", 1, 1, 0, 0);

    // Reset after six bytes, start held across release.
    clear_log();
    press(1, 0);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h40 + i));
    load_start = 1'b1;
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check("arst_we",    32'(imem_we),   32'd0);
    check("arst_addr",  32'(imem_addr), 32'd0);
    check("arst_wdata", imem_wdata,     32'd0);
    check_state("arst", 0, 0, 0, 0);
    cyc(3);
    reset = 1'b0;
    cyc(10);
    repeat (4) send_byte(8'h99);
    check("held_nwr", wlog_addr.size(), 32'd1);
    load_start = 1'b0;
    cyc(4);
    press(0, 1);
    check_state("held", 0, 0, 0, 0);

    // A fresh press after release is accepted again.
    press(1, 0);
    send_byte(8'h5A); send_byte(8'h5B); send_byte(8'h5C); send_byte(8'h5D);
    press(0, 1);
    check("fresh_nwr", wlog_addr.size(), 32'd2);
    if (wlog_addr.size() == 2) check("fresh_d", wlog_data[1], 32'h5A5B_5C5D);
    check_state("fresh", 1, 1, 0, 0);

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
